// File: rtl/synth_env_pkg.sv
// Shared types for the time-multiplexed ADSR envelope engine.
// ENV_EXP_RELEASE_EN selects exponential decay/release steps.
package synth_env_pkg;

  localparam int ENV_L_WIDTH = 16;
  localparam logic [ENV_L_WIDTH-1:0] LVL_MAX = '1;

  // Five stages do not fit in two bits, so the stage field is three bits wide.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_stage_t;

  typedef struct packed {
    env_stage_t             stage;
    logic [ENV_L_WIDTH-1:0] level;
    logic                   prev_gate;
  } slot_state_t;

`ifdef ENV_EXP_RELEASE_EN
  // A zero rate still holds; otherwise step never drops below one LSB.
  function automatic logic [ENV_L_WIDTH-1:0] exp_step(input logic [ENV_L_WIDTH-1:0] lvl,
                                                      input logic [ENV_L_WIDTH-1:0] rate);
    logic [ENV_L_WIDTH-1:0] sh;
    sh = lvl >> rate[3:0];
    if (rate == '0)     exp_step = '0;
    else if (sh == '0)  exp_step = {{(ENV_L_WIDTH-1){1'b0}}, 1'b1};
    else                exp_step = sh;
  endfunction
`endif

endpackage

// File: rtl/env_slot_ram.sv
// Per-slot envelope state store: one synchronous read port, one write port.
module env_slot_ram
  import synth_env_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic [AW-1:0] i_raddr,
  output slot_state_t   o_rdata,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  slot_state_t   i_wdata
);

  slot_state_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/env_gen_mux.sv
// Time-multiplexed ADSR engine: one envelope slot per cycle, latency 2.
// ENV_EXP_RELEASE_EN: decay/release step = max(level >> rate[3:0], 1).
module env_gen_mux
  import synth_env_pkg::*;
#(
  parameter int VOICES  = 8,
  parameter int V_ENVS  = 8,
  parameter int V_WIDTH = 3,
  parameter int E_WIDTH = 3,
  parameter int L_WIDTH = ENV_L_WIDTH
) (
  input  logic                       sCLK_XVXENVS,
  input  logic                       reset_reg,
  input  logic [V_WIDTH+E_WIDTH-1:0] xxxx,
  input  logic                       xxxx_zero,
  input  logic [VOICES-1:0]          voice_gate,
  output logic [V_WIDTH+E_WIDTH-1:0] param_addr,
  input  logic [L_WIDTH-1:0]         atk_rate,
  input  logic [L_WIDTH-1:0]         dec_rate,
  input  logic [L_WIDTH-1:0]         sus_lvl,
  input  logic [L_WIDTH-1:0]         rel_rate,
  output logic [L_WIDTH-1:0]         env_level,
  output logic [V_WIDTH+E_WIDTH-1:0] env_slot,
  output logic                       env_valid,
  output logic                       env_frame
);

  localparam int SW    = V_WIDTH + E_WIDTH;
  localparam int DEPTH = VOICES * V_ENVS;

  logic [1:0]         r_vld_pipe;
  logic [SW-1:0]      r_slot1, r_slot2;
  logic               r_zero1, r_gate1, r_frame2;
  logic [L_WIDTH-1:0] r_lvl2;
  logic               r_init, r_armed;

  slot_state_t        w_rd, w_nxt, w_wdata;
  logic [L_WIDTH:0]   w_sum;
  logic [L_WIDTH-1:0] w_dstep, w_rstep;

  assign param_addr = xxxx;

  env_slot_ram #(.DEPTH(DEPTH), .AW(SW)) u_ram (
    .clk     (sCLK_XVXENVS),
    .i_raddr (xxxx),
    .o_rdata (w_rd),
    .i_we    (r_vld_pipe[0]),
    .i_waddr (r_slot1),
    .i_wdata (w_wdata)
  );

  always_comb begin
    w_nxt           = w_rd;
    w_nxt.prev_gate = r_gate1;
    w_sum           = {1'b0, w_rd.level} + {1'b0, atk_rate};
`ifdef ENV_EXP_RELEASE_EN
    w_dstep = exp_step(w_rd.level, dec_rate);
    w_rstep = exp_step(w_rd.level, rel_rate);
`else
    w_dstep = dec_rate;
    w_rstep = rel_rate;
`endif
    // Gate edges win over the in-stage update; the level is carried unchanged.
    if (r_gate1 && !w_rd.prev_gate) begin
      w_nxt.stage = ST_ATTACK;
    end else if (!r_gate1 && (w_rd.stage inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
      w_nxt.stage = ST_RELEASE;
    end else begin
      case (w_rd.stage)
        ST_ATTACK: begin
          if (atk_rate != '0) begin
            if (w_sum >= {1'b0, LVL_MAX}) begin
              w_nxt.level = LVL_MAX;
              w_nxt.stage = ST_DECAY;
            end else begin
              w_nxt.level = w_sum[L_WIDTH-1:0];
            end
          end
        end
        ST_DECAY: begin
          if (w_rd.level <= sus_lvl || w_dstep >= w_rd.level - sus_lvl) begin
            w_nxt.level = sus_lvl;
            w_nxt.stage = ST_SUSTAIN;
          end else begin
            w_nxt.level = w_rd.level - w_dstep;
          end
        end
        ST_SUSTAIN: w_nxt.level = sus_lvl;
        ST_RELEASE: begin
          if (w_rstep >= w_rd.level) begin
            w_nxt.level = '0;
            w_nxt.stage = ST_IDLE;
          end else begin
            w_nxt.level = w_rd.level - w_rstep;
          end
        end
        default: ;
      endcase
    end
    w_wdata = r_init ? slot_state_t'{stage: ST_IDLE, level: '0, prev_gate: 1'b0} : w_nxt;
  end

  always_ff @(posedge sCLK_XVXENVS) begin
    if (reset_reg) begin
      r_vld_pipe <= '0;
      r_slot1    <= '0;
      r_zero1    <= 1'b0;
      r_gate1    <= 1'b0;
      r_slot2    <= '0;
      r_lvl2     <= '0;
      r_frame2   <= 1'b0;
      r_init     <= 1'b1;
      r_armed    <= 1'b0;
      env_level  <= '0;
      env_slot   <= '0;
      env_valid  <= 1'b0;
      env_frame  <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0] & ~r_init, 1'b1};
      r_slot1    <= xxxx;
      r_zero1    <= xxxx_zero;
      r_gate1    <= voice_gate[xxxx[SW-1:E_WIDTH]];
      r_slot2    <= r_slot1;
      r_lvl2     <= w_nxt.level;
      r_frame2   <= r_zero1;
      // The clear sweep only ends once it has covered slot 0 through the last slot.
      if (r_vld_pipe[0] && r_init) begin
        if (r_slot1 == '0) r_armed <= 1'b1;
        if (r_zero1 && r_armed) begin
          r_init  <= 1'b0;
          r_armed <= 1'b0;
        end
      end
      env_valid <= r_vld_pipe[1];
      env_level <= r_lvl2;
      env_slot  <= r_slot2;
      env_frame <= r_vld_pipe[1] & r_frame2;
    end
  end

endmodule

// File: tb/tb_env_gen_mux.sv
// Bench for env_gen_mux: directed ADSR scenarios plus random gates/params vs a slot model.
module tb_env_gen_mux;

  localparam int SLOTS = 64;
  localparam int M_IDLE = 0, M_ATK = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;
`ifdef ENV_EXP_RELEASE_EN
  localparam int REL_P = 4, REL1 = 'h7800, REATK = 'hB800;
`else
  localparam int REL_P = 'h2000, REL1 = 'h6000, REATK = 'hA000;
`endif

  logic        clk = 1'b0;
  logic        reset_reg;
  logic [5:0]  xxxx, param_addr, env_slot, idx;
  logic        xxxx_zero, env_valid, env_frame;
  logic [7:0]  voice_gate;
  logic [15:0] atk_rate, dec_rate, sus_lvl, rel_rate, env_level;

  always #5 clk = ~clk;

  env_gen_mux #(.VOICES(8), .V_ENVS(8), .V_WIDTH(3), .E_WIDTH(3), .L_WIDTH(16)) dut (
    .sCLK_XVXENVS(clk), .reset_reg(reset_reg), .xxxx(xxxx), .xxxx_zero(xxxx_zero),
    .voice_gate(voice_gate), .param_addr(param_addr), .atk_rate(atk_rate),
    .dec_rate(dec_rate), .sus_lvl(sus_lvl), .rel_rate(rel_rate), .env_level(env_level),
    .env_slot(env_slot), .env_valid(env_valid), .env_frame(env_frame)
  );

  int atk_m [SLOTS];
  int dec_m [SLOTS];
  int sus_m [SLOTS];
  int rel_m [SLOTS];

  // External synchronous parameter RAM
  always @(posedge clk) begin
    atk_rate <= 16'(atk_m[param_addr]);
    dec_rate <= 16'(dec_m[param_addr]);
    sus_lvl  <= 16'(sus_m[param_addr]);
    rel_rate <= 16'(rel_m[param_addr]);
  end

  typedef struct { bit v; bit fr; int slot; int lvl; } exp_t;
  exp_t q[$];
  int   m_st [SLOTS];
  int   m_lvl [SLOTS];
  bit   m_prev [SLOTS];
  bit   m_init, m_start;
  int   tests, fails, cnt_valid, cnt_frame, cnt_nz, obs16;

`ifdef ENV_EXP_RELEASE_EN
  function automatic int exp_step(int lvl, int rate);
    int s;
    if (rate == 0) return 0;
    s = lvl >> (rate & 15);
    return (s < 1) ? 1 : s;
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_visit(input int s);
    exp_t e;
    int g, lv, st, ds, rs;
    e.slot = s; e.v = 0; e.fr = 0; e.lvl = 0;
    if (m_init) begin
      m_st[s] = M_IDLE; m_lvl[s] = 0; m_prev[s] = 0;
      if (s == 0) m_start = 1;
      if (s == SLOTS-1 && m_start) m_init = 0;
    end else begin
      g  = int'(voice_gate[s/8]);
      lv = m_lvl[s];
      st = m_st[s];
`ifdef ENV_EXP_RELEASE_EN
      ds = exp_step(lv, dec_m[s]);
      rs = exp_step(lv, rel_m[s]);
`else
      ds = dec_m[s];
      rs = rel_m[s];
`endif
      if (g == 1 && !m_prev[s]) st = M_ATK;
      else if (g == 0 && (st == M_ATK || st == M_DEC || st == M_SUS)) st = M_REL;
      else begin
        case (st)
          M_ATK: if (atk_m[s] != 0) begin
            if (lv + atk_m[s] >= 65535) begin lv = 65535; st = M_DEC; end
            else lv = lv + atk_m[s];
          end
          M_DEC: if (lv - ds <= sus_m[s]) begin lv = sus_m[s]; st = M_SUS; end
                 else lv = lv - ds;
          M_SUS: lv = sus_m[s];
          M_REL: if (lv - rs <= 0) begin lv = 0; st = M_IDLE; end
                 else lv = lv - rs;
          default: ;
        endcase
      end
      m_st[s] = st; m_lvl[s] = lv; m_prev[s] = (g == 1);
      e.v = 1; e.fr = (s == SLOTS-1); e.lvl = lv;
    end
    q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    xxxx      = idx;
    xxxx_zero = (idx == 6'd63);
    @(posedge clk);
    if (reset_reg) begin
      q.delete(); m_init = 1; m_start = 0;
    end else begin
      model_visit(int'(idx));
    end
    idx = idx + 6'd1;
    #1;
    if (reset_reg) begin
      chk("rst_valid", 32'(env_valid), 0);
      chk("rst_level", 32'(env_level), 0);
      chk("rst_slot",  32'(env_slot),  0);
      chk("rst_frame", 32'(env_frame), 0);
    end else if (q.size() == 3) begin
      e = q.pop_front();
      chk("valid", 32'(env_valid), 32'(e.v));
      chk("frame", 32'(env_frame), 32'(e.fr));
      if (e.v) begin
        chk("slot",  32'(env_slot),  e.slot);
        chk("level", 32'(env_level), e.lvl);
      end
    end else begin
      chk("fill_valid", 32'(env_valid), 0);
    end
    if (env_valid === 1'b1) begin
      cnt_valid++;
      if (env_level != 16'd0) cnt_nz++;
      if (env_slot == 6'd16) obs16 = int'(env_level);
    end
    if (env_frame === 1'b1) cnt_frame++;
  endtask

  task automatic run_frames(input int n);
    repeat (n * SLOTS) step();
  endtask

  task automatic set_voice(input int v, input int a, input int d, input int su, input int r);
    for (int e = 0; e < 8; e++) begin
      atk_m[v*8+e] = a; dec_m[v*8+e] = d; sus_m[v*8+e] = su; rel_m[v*8+e] = r;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; cnt_valid = 0; cnt_frame = 0; cnt_nz = 0; obs16 = -1;
    for (int s = 0; s < SLOTS; s++) begin
      atk_m[s] = 0; dec_m[s] = 0; sus_m[s] = 0; rel_m[s] = 0;
    end
    voice_gate = '0; reset_reg = 1'b1; idx = '0; xxxx = '0; xxxx_zero = 1'b0;
    m_init = 1; m_start = 0;

    repeat (3) step();
    idx = '0; reset_reg = 1'b0;
    run_frames(2); step(); step();
    chk("clear_frame_valid_count", cnt_valid, 64);
    chk("frame_flag_count", cnt_frame, 1);
    chk("second_frame_zero", cnt_nz, 0);

    set_voice(2, 'h4000, 'h1000, 'h8000, REL_P);
    voice_gate[2] = 1'b1;
    run_frames(5);  chk("attack_peak", obs16, 'hFFFF);
    run_frames(8);  chk("decay_to_sustain", obs16, 'h8000);
    set_voice(2, 'h4000, 'h1000, 'h7000, REL_P);
    run_frames(1);  chk("sustain_tracks", obs16, 'h7000);
    set_voice(2, 'h4000, 'h1000, 'h8000, REL_P);
    run_frames(1);  chk("sustain_restore", obs16, 'h8000);
    voice_gate[2] = 1'b0;
    run_frames(2);  chk("release_first", obs16, REL1);
    voice_gate[2] = 1'b1;
    run_frames(2);  chk("reattack_from_level", obs16, REATK);
    run_frames(2);  chk("reattack_peak", obs16, 'hFFFF);
    run_frames(8);  chk("sustain_again", obs16, 'h8000);
`ifndef ENV_EXP_RELEASE_EN
    voice_gate[2] = 1'b0;
    run_frames(4);  chk("release_mid", obs16, 'h2000);
    run_frames(1);  chk("release_zero", obs16, 0);
    run_frames(1);  chk("idle_zero", obs16, 0);
    voice_gate[2] = 1'b1;
    run_frames(3);  chk("attack_after_idle", obs16, 'h8000);
`endif

    // Reset mid-frame with voice 2 active
    while (idx != 6'd20) step();
    reset_reg = 1'b1;
    step(); step();
    reset_reg = 1'b0;
    cnt_valid = 0; cnt_nz = 0; cnt_frame = 0;
    repeat (42 + 64 + 64 + 2) step();
    chk("midreset_valid_count", cnt_valid, 64);
    chk("midreset_levels_zero", cnt_nz, 0);
    chk("midreset_frame_count", cnt_frame, 1);

    // Random gates and parameters against the model
    for (int f = 0; f < 12; f++) begin
      voice_gate = 8'($urandom);
      for (int s = 0; s < SLOTS; s++) begin
        atk_m[s] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 'h6000));
        dec_m[s] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 'h3000));
        rel_m[s] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 'h3000));
        sus_m[s] = int'($urandom_range(0, 'hFFFF));
      end
      run_frames(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
